seq_scan_ctrl: RTL and testbench
================================

// Module: seq_scan_ctrl
// PURPOSE
//  Sequences parallel words through a bit-serial pattern detector. Accepts one WORD_W-bit
//  word per valid/ready handshake and shifts it MSB-first, one bit per clk, into an embedded
//  PATTERN matcher. Returns the match count, a found flag and the bit index of the first match.
//  Sits between the word-level datapath and the serial detector; the only sequencer for it.
// PARAMETERS
//  WORD_W   16      bits per scanned word (>= PAT_LEN)
//  PAT_LEN  3       pattern length in bits (2..8)
//  PATTERN  3'b010  pattern; its MSB is matched first in time
//  CNT_W    $clog2(WORD_W+1)  width of out_count (derived, not overridden)
//  IDX_W    $clog2(WORD_W)    width of out_first_idx (derived, not overridden)
// PORTS
//  clk            in   1      single clock, rising edge
//  reset_n        in   1      synchronous, active-low reset
//  in_valid       in   1      word offered
//  in_ready       out  1      controller idle; accepts a word
//  in_word        in   WORD_W word to scan; bit WORD_W-1 is scanned first (index 0)
//  abort          in   1      synchronous cancel of the scan in progress
//  out_valid      out  1      result held valid until accepted
//  out_ready      in   1      result consumer ready
//  out_count      out  CNT_W  number of matches in the word
//  out_found      out  1      out_count != 0
//  out_first_idx  out  IDX_W  scan index of the bit that completed the first match; 0 if none
//  busy           out  1      state != IDLE
// BEHAVIOUR
//  - FSM states: IDLE -> SHIFT -> DONE -> IDLE. in_ready = (state==IDLE); busy = !IDLE.
//  - Reset (reset_n=0 at a clk edge): state=IDLE. out_valid=0, out_count=0, out_found=0,
//    out_first_idx=0, history/fill/bit counters=0. After the edge: in_ready=1, busy=0.
//    Reset in any state discards the current scan.
//  - IDLE: on in_valid&&in_ready, latch in_word and clear history, fill count, bit index and
//    match count. Go to SHIFT.
//  - SHIFT: each cycle shift one bit into history, shift left, LSB = new bit. fill saturates at PAT_LEN.
//    A match occurs when fill (including this bit) >= PAT_LEN and the new history equals PATTERN.
//    On a match, increment count. On the first match, record the current bit index.
//    After the bit at index WORD_W-1, go to DONE.
//  - Latency: handshake at edge 0; bits consumed at edges 1..WORD_W;
//    out_valid=1 from edge WORD_W+1.
//  - DONE: out_valid=1. out_* stay stable until out_valid&&out_ready, then IDLE.
//    No same-cycle bypass: in_ready rises the cycle after the result handshake.
//  - abort=1 in SHIFT or DONE: next state IDLE, out_valid=0, result discarded.
//    abort in IDLE is ignored. abort has priority over out_ready and over a final-bit transition.
//  - in_valid while busy is ignored. in_word is sampled only at the handshake.
//  - out_count cannot overflow: max WORD_W-PAT_LEN+1 < 2^CNT_W.
// CONFIGURATION
//  SEQ_SCAN_OVERLAP_EN defined: overlapping matches count. History and fill are kept after a
//    match, e.g. "01010" with PATTERN 010 gives 2 matches.
//  Undefined: history and fill clear on each match; matching restarts with the next bit.
//    "01010" gives 1 match.
// STRUCTURE
//  Package seq_scan_pkg holds:
//   - state enum (IDLE/SHIFT/DONE) and its encoding width;
//   - the default PATTERN/PAT_LEN localparams.
//  Sub-module seq_match_core holds the history shift register, fill counter and comparator.
//   - Inputs: bit_in, bit_en, clear.
//   - Output: match (combinational on the new history).
//   - Clock/reset: same clk, reset_n.
//   - Owns the overlap macro.
//  The controller holds the FSM, word shifter, bit index, count and first-index capture.
// TESTING  (WORD_W=16, PAT_LEN=3, PATTERN=3'b010)
//  1 in_word=16'h0000 -> out_valid at edge 17; count=0, found=0, first_idx=0.
//  2 in_word=16'h5000 -> first_idx=2, found=1. Count=2 with OVERLAP_EN, count=1 without.
//  3 in_word=16'h5555 -> first_idx=2. Count=7 with OVERLAP_EN, count=4 without.
//  4 out_ready=0 for 5 cycles in DONE -> out_* stable, in_ready=0.
//    Then handshake -> in_ready=1 next cycle, next word accepted.
//  5 abort=1 at the 5th SHIFT cycle -> IDLE next edge, no out_valid.
//    Then scan 16'h5555 -> count unaffected (7/4).
//  6 reset_n=0 mid-SHIFT, then in DONE -> all outputs at reset values after the edge,
//    in_ready=1, no stale result.

Source files
------------

// File: rtl/seq_scan_pkg.sv
// Shared types and default pattern settings for the sequenced serial pattern scanner.
package seq_scan_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int             DEF_PAT_LEN = 3;
  localparam logic [7:0]     DEF_PATTERN = 8'b0000_0010;

endpackage

// File: rtl/seq_match_core.sv
// Bit-serial pattern matcher: history shift register, saturating fill counter, comparator.
// SEQ_SCAN_OVERLAP_EN keeps history after a match so overlapping occurrences count.
module seq_match_core
  import seq_scan_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic bit_in,
  input  logic bit_en,
  input  logic clear,
  output logic match
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);

  logic [PAT_LEN-1:0] hist_q, hist_d, hist_new;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_new;

  always_comb begin
    hist_new = {hist_q[PAT_LEN-2:0], bit_in};
    fill_new = (fill_q == FILL_W'(PAT_LEN)) ? fill_q : fill_q + FILL_W'(1);
    match    = bit_en && (fill_new == FILL_W'(PAT_LEN)) && (hist_new == PATTERN);

    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bit_en) begin
`ifdef SEQ_SCAN_OVERLAP_EN
      hist_d = hist_new;
      fill_d = fill_new;
`else
      // A match consumes its bits; the next search starts from an empty history.
      hist_d = match ? '0 : hist_new;
      fill_d = match ? '0 : fill_new;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-to-serial sequencer: shifts each accepted word MSB-first through seq_match_core
// and reports match count, found flag and first-match index. Overlap mode: SEQ_SCAN_OVERLAP_EN.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int                 WORD_W  = 16,
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
  parameter int                 CNT_W   = $clog2(WORD_W + 1),
  parameter int                 IDX_W   = $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_found,
  output logic [IDX_W-1:0]  out_first_idx,
  output logic              busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   first_idx_q, first_idx_d;
  logic               found_q, found_d;
  logic               valid_q, valid_d;
  logic               clear, bit_en, match;

  assign bit_en = (state_q == SHIFT);

  seq_match_core #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_match (
    .clk     (clk),
    .reset_n (reset_n),
    .bit_in  (word_q[WORD_W-1]),
    .bit_en  (bit_en),
    .clear   (clear),
    .match   (match)
  );

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    bit_idx_d   = bit_idx_q;
    count_d     = count_q;
    first_idx_d = first_idx_q;
    found_d     = found_q;
    valid_d     = valid_q;
    clear       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d      = in_word;
          bit_idx_d   = '0;
          count_d     = '0;
          first_idx_d = '0;
          found_d     = 1'b0;
          clear       = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        word_d    = word_q << 1;
        bit_idx_d = bit_idx_q + IDX_W'(1);
        if (match) begin
          count_d = count_q + CNT_W'(1);
          found_d = 1'b1;
          if (count_q == '0) first_idx_d = bit_idx_q;
        end
        if (abort)                      state_d = IDLE;
        else if (bit_idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        // The result becomes visible one cycle after entering DONE.
        if (abort || (valid_q && out_ready)) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      word_q      <= '0;
      bit_idx_q   <= '0;
      count_q     <= '0;
      first_idx_q <= '0;
      found_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      bit_idx_q   <= bit_idx_d;
      count_q     <= count_d;
      first_idx_q <= first_idx_d;
      found_q     <= found_d;
      valid_q     <= valid_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign out_valid     = valid_q;
  assign out_count     = count_q;
  assign out_found     = found_q;
  assign out_first_idx = first_idx_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl (WORD_W=16, PATTERN=3'b010), both overlap configurations.
module tb_seq_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_word;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_count;
  logic        out_found;
  logic [3:0]  out_first_idx;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef SEQ_SCAN_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  seq_scan_ctrl #(.WORD_W(16), .PAT_LEN(3), .PATTERN(3'b010)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_word       (in_word),
    .abort         (abort),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_count     (out_count),
    .out_found     (out_found),
    .out_first_idx (out_first_idx),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    int          cnt_ovl;
    int          cnt_no;
    int          first;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake(input logic [15:0] w);
    chk("in_ready_before_hs", int'(in_ready), 1);
    in_valid = 1'b1;
    in_word  = w;
    tick();
    in_valid = 1'b0;
    in_word  = ~w;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic check_result(input string tag, input int cnt, input int first);
    int exp_cnt_found;
    exp_cnt_found = (cnt != 0) ? 1 : 0;
    chk({tag, "_count"}, int'(out_count), cnt);
    chk({tag, "_found"}, int'(out_found), exp_cnt_found);
    chk({tag, "_first_idx"}, int'(out_first_idx), first);
  endtask

  task automatic scan(input string tag, input logic [15:0] w, input int cnt, input int first);
    int n;
    handshake(w);
    chk({tag, "_busy"}, int'(busy), 1);
    wait_valid(n);
    chk({tag, "_latency"}, n, 17);
    check_result(tag, cnt, first);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, int'(out_valid), 0);
    chk({tag, "_in_ready_after"}, int'(in_ready), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_count"}, int'(out_count), 0);
    chk({tag, "_out_found"}, int'(out_found), 0);
    chk({tag, "_out_first"}, int'(out_first_idx), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int n;
    int cnt5555;
    logic [4:0] hold_cnt;
    logic [3:0] hold_idx;

    vecs[0] = '{16'h0000, 0, 0, 0};
    vecs[1] = '{16'h5000, 2, 1, 2};
    vecs[2] = '{16'h5555, 7, 4, 2};
    vecs[3] = '{16'hFFFF, 0, 0, 0};
    vecs[4] = '{16'h4000, 1, 1, 2};
    vecs[5] = '{16'h8002, 1, 1, 15};
    vecs[6] = '{16'hAAAA, 7, 4, 3};
    cnt5555 = OVL ? 7 : 4;

    reset_n = 1'b0; in_valid = 1'b0; in_word = '0; abort = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      scan($sformatf("vec%0d", i), vecs[i].word,
           OVL ? vecs[i].cnt_ovl : vecs[i].cnt_no, vecs[i].first);
    end

    // Backpressure: result held while out_ready is low, extra in_valid ignored.
    handshake(16'h5555);
    wait_valid(n);
    chk("bp_latency", n, 17);
    hold_cnt = out_count;
    hold_idx = out_first_idx;
    in_valid = 1'b1;
    in_word  = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid_hold", int'(out_valid), 1);
      chk("bp_count_hold", int'(out_count), int'(hold_cnt));
      chk("bp_idx_hold", int'(out_first_idx), int'(hold_idx));
      chk("bp_in_ready_low", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    check_result("bp", cnt5555, 2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_in_ready_next", int'(in_ready), 1);
    scan("bp_next", 16'h4000, 1, 2);

    // Abort during the fifth SHIFT cycle.
    handshake(16'h5555);
    for (int k = 0; k < 4; k++) tick();
    chk("abort_busy_before", int'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_busy", int'(busy), 0);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid) chk("abort_no_valid", int'(out_valid), 0);
    end
    chk("abort_idle_valid", int'(out_valid), 0);
    scan("after_abort", 16'h5555, cnt5555, 2);

    // Abort while the result is waiting in DONE.
    handshake(16'h5000);
    wait_valid(n);
    abort = 1'b1;
    out_ready = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    chk("abort_done_valid", int'(out_valid), 0);
    chk("abort_done_in_ready", int'(in_ready), 1);

    // Reset mid-SHIFT, then reset while DONE.
    handshake(16'h5555);
    for (int k = 0; k < 6; k++) tick();
    reset_n = 1'b0;
    tick();
    check_reset_outputs("rst_shift");
    reset_n = 1'b1;
    handshake(16'h5555);
    wait_valid(n);
    chk("rst_done_reached", int'(out_valid), 1);
    reset_n = 1'b0;
    tick();
    check_reset_outputs("rst_done");
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    chk("rst_no_stale", int'(out_valid), 0);
    scan("after_reset", 16'h5000, OVL ? 2 : 1, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
